// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: forward-select codes
// and the multi-cycle unit state encoding.
package hazard_fwd_unit_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Wide enough for the largest legal multi-cycle latency (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WB   = 2'd2
    } mc_state_t;

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// One operand's forwarding mux select: EX/MEM result wins over MEM/WB,
// and register 0 is never forwarded.
module fwd_select
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] rd_EXMEM,
    input  logic [REG_AW-1:0] rd_MEMWB,
    input  logic              reg_write_EXMEM,
    input  logic              reg_write_MEMWB,
    output logic [1:0]        fwd
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = reg_write_EXMEM && (rd_EXMEM != '0) && (rd_EXMEM == src);
    assign hit_memwb = reg_write_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == src);

    always_comb begin
        fwd = FWD_NONE;
        if (hit_exmem) begin
            fwd = FWD_EXMEM;
        end else if (hit_memwb) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: operand forwarding, load-use interlock, and
// tracking of a single non-pipelined multi-cycle execution unit.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MC_LAT   = 4,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_AW-1:0]   rs_ID,
    input  logic [REG_AW-1:0]   rt_ID,
    input  logic [REG_AW-1:0]   rs_IDEX,
    input  logic [REG_AW-1:0]   rt_IDEX,
    input  logic [REG_AW-1:0]   rd_IDEX,
    input  logic                mem_read_IDEX,
    input  logic [REG_AW-1:0]   rd_EXMEM,
    input  logic [REG_AW-1:0]   rd_MEMWB,
    input  logic                reg_write_EXMEM,
    input  logic                reg_write_MEMWB,
    input  logic                mc_issue,
    input  logic [REG_AW-1:0]   mc_rd,
    input  logic                flush,
    output logic [1:0]          forwardA,
    output logic [1:0]          forwardB,
    output logic                stall,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                idex_bubble,
    output logic                mc_wb,
    output logic [REG_AW-1:0]   mc_wb_rd,
    output logic                mc_busy,
    output logic [STALL_CW-1:0] stall_count
);

    mc_state_t         state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [REG_AW-1:0] pend_rd, pend_rd_next;

    logic load_use;
    logic raw_mc;
    logic struct_mc;
    logic issue_accept;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src             (rs_IDEX),
        .rd_EXMEM        (rd_EXMEM),
        .rd_MEMWB        (rd_MEMWB),
        .reg_write_EXMEM (reg_write_EXMEM),
        .reg_write_MEMWB (reg_write_MEMWB),
        .fwd             (forwardA)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src             (rt_IDEX),
        .rd_EXMEM        (rd_EXMEM),
        .rd_MEMWB        (rd_MEMWB),
        .reg_write_EXMEM (reg_write_EXMEM),
        .reg_write_MEMWB (reg_write_MEMWB),
        .fwd             (forwardB)
    );

    assign mc_busy   = (state != ST_IDLE);
    assign load_use  = mem_read_IDEX && (rd_IDEX != '0) &&
                       ((rd_IDEX == rs_ID) || (rd_IDEX == rt_ID));
    assign raw_mc    = mc_busy && (pend_rd != '0) &&
                       ((pend_rd == rs_ID) || (pend_rd == rt_ID));
    assign struct_mc = mc_issue && mc_busy;

    // All three hazard sources fold into one stall so overlapping causes
    // cost a single cycle and a single count. Reset holds the pipe open.
    assign stall       = (load_use || raw_mc || struct_mc) && !flush && !rst;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall;

    // Issue handshake: mc_issue acts as valid, (!stall && !flush && idle)
    // as ready; the op transfers in the cycle both are true and decode
    // must hold mc_issue/mc_rd stable until then.
    assign issue_accept = mc_issue && !stall && !flush && (state == ST_IDLE);

    assign mc_wb    = (state == ST_WB);
    assign mc_wb_rd = (state == ST_WB) ? pend_rd : '0;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pend_rd_next = pend_rd;
        case (state)
            ST_IDLE: begin
                if (issue_accept) begin
                    state_next   = ST_BUSY;
                    cnt_next     = CNT_W'(MC_LAT - 1);
                    pend_rd_next = mc_rd;
                end
            end
            ST_BUSY: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pend_rd     <= '0;
            stall_count <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pend_rd <= pend_rd_next;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MC_LAT, default 4, multi-cycle unit latency in cycles, legal range 2..15.
REQ-003 SHALL have parameter STALL_CW, default 16, stall-counter width.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset (one clock; reset is synchronous and active-high).
REQ-005 SHALL have ports: rs_ID, rt_ID in REG_AW, decode-stage sources; rs_IDEX, rt_IDEX, rd_IDEX in REG_AW, execute-stage fields.
REQ-006 SHALL have ports: mem_read_IDEX in 1; rd_EXMEM, rd_MEMWB in REG_AW; reg_write_EXMEM, reg_write_MEMWB in 1.
REQ-007 SHALL have ports: mc_issue in 1, decode holds a multi-cycle op; mc_rd in REG_AW, its destination; flush in 1, decode instruction squashed.
REQ-008 SHALL have ports: forwardA, forwardB out 2; stall out 1; pc_write, ifid_write, idex_bubble out 1; mc_wb out 1; mc_wb_rd out REG_AW; mc_busy out 1; stall_count out STALL_CW.

Function
REQ-009 forwardA SHALL be 10 if reg_write_EXMEM, rd_EXMEM!=0, rd_EXMEM==rs_IDEX; else 01 if same test on MEMWB; else 00. forwardB identical against rt_IDEX. Combinational, zero latency.
REQ-010 load_use SHALL be mem_read_IDEX & rd_IDEX!=0 & (rd_IDEX==rs_ID | rd_IDEX==rt_ID).
REQ-011 FSM states IDLE, BUSY, WB; single non-pipelined multi-cycle unit.
REQ-012 Issue accepted in cycle T iff mc_issue & !stall & !flush & state==IDLE; then pend_rd<=mc_rd, cnt<=MC_LAT-1, state<=BUSY.
REQ-013 BUSY: cnt decrements each cycle; when cnt==1 next state WB. WB lasts one cycle, then IDLE.
REQ-014 mc_wb SHALL be 1 exactly in cycle T+MC_LAT (state WB) with mc_wb_rd=pend_rd; else mc_wb=0, mc_wb_rd=0.
REQ-015 mc_busy SHALL be 1 in states BUSY and WB.
REQ-016 raw_mc SHALL be mc_busy & pend_rd!=0 & (pend_rd==rs_ID | pend_rd==rt_ID); struct_mc SHALL be mc_issue & mc_busy.
REQ-017 stall SHALL be (load_use | raw_mc | struct_mc) & !flush; pc_write=ifid_write=!stall; idex_bubble=stall.
REQ-018 Dependent instruction SHALL be released in cycle T+MC_LAT+1; a new mc_issue SHALL be accepted no earlier than T+MC_LAT+1.
REQ-019 mc_rd==0 SHALL still occupy the unit and produce mc_wb, but SHALL never cause raw_mc.
REQ-020 flush SHALL not cancel an op already in BUSY/WB.
REQ-021 stall_count SHALL increment by 1 each cycle stall==1, saturating at all-ones.
REQ-022 Simultaneous load_use and raw_mc SHALL produce a single stall, counted once.

Reset
REQ-023 rst SHALL, at the clock edge, force state IDLE, cnt=0, pend_rd=0, stall_count=0.
REQ-024 rst during BUSY or WB SHALL abandon the op: no mc_wb after reset.
REQ-025 While rst high, mc_wb=0, mc_busy=0, stall=0 (pc_write=ifid_write=1, idex_bubble=0) from the next edge on; forward outputs remain combinational.

Structure
REQ-026 Shared package SHALL hold FWD_NONE=00, FWD_MEMWB=01, FWD_EXMEM=10 and the FSM state encoding.
REQ-027 Sub-module fwd_select SHALL implement one operand's REQ-009 priority compare, instantiated twice.

Verification
REQ-028 rd_EXMEM=rd_MEMWB=rs_IDEX=3, both write enables 1 -> forwardA=10; clear reg_write_EXMEM -> 01; rs_IDEX=0 with rd=0 -> 00.
REQ-029 mem_read_IDEX=1, rd_IDEX=5, rt_ID=5 -> stall=1, pc_write=0, idex_bubble=1 for one cycle; stall_count 0->1.
REQ-030 MC_LAT=4, mc_issue with mc_rd=7 at T, rs_ID=7 from T+1 -> stall T+1..T+4, mc_wb=1 with mc_wb_rd=7 only at T+4, stall=0 at T+5.
REQ-031 Second mc_issue (mc_rd=9) held from T+1 -> stall until T+4, accepted at T+5, mc_wb at T+9.
REQ-032 rst asserted at T+2 of an op -> mc_busy=0, no mc_wb at T+4, stall_count=0.
REQ-033 flush=1 with load_use true and mc_issue=1 -> stall=0, no issue accepted, stall_count unchanged.
